// File: rtl/wb_keypad_scanner.sv
// Wishbone slave that scans a 4x3 matrix keypad, debounces full scans and
// queues one key code per accepted press in a small FIFO with optional irq.
module wb_keypad_scanner #(
    parameter int COL_CYCLES = 100000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic [3:0]  row_i,
    output logic [2:0]  col_o,
    output logic        irq
);
    localparam int CW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
    localparam int PW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic {S_IDLE, S_DRIVE} state_t;

    state_t          state_reg;
    logic [3:0]      row_meta_reg, row_sync_reg;
    logic [1:0]      col_idx_reg;
    logic [CW-1:0]   dwell_reg;
    logic [11:0]     scan_reg, prev_scan_reg;
    logic            scan_done_reg;
    logic [PW-1:0]   press_cnt_reg, press_next, rel_cnt_reg, rel_next;
    logic            armed_reg;
    logic            enable_reg, irq_en_reg;
    logic [3:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [NW-1:0]   count_reg;
    logic            overflow_reg;

    logic [1:0]      reg_sel;
    logic            access, ctrl_wr, ovf_clr, rd_pop, en_eff;
    logic            not_empty, full, push, push_ok, v_onehot;
    logic [3:0]      key_code;
    logic [31:0]     status_word, data_word, rd_word;
    logic            unused_bits;

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:2]};

    assign reg_sel   = wb_adr_i[3:2];
    assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign not_empty = (count_reg != '0);
    assign full      = (count_reg == NW'(FIFO_DEPTH));
    assign ctrl_wr   = access & wb_we_i & (reg_sel == 2'd2);
    assign ovf_clr   = access & wb_we_i & (reg_sel == 2'd0) & wb_dat_i[1];
    assign rd_pop    = access & ~wb_we_i & (reg_sel == 2'd1) & not_empty;
    // A CTRL write takes effect on the scanner in the same cycle it is acked.
    assign en_eff    = ctrl_wr ? wb_dat_i[0] : enable_reg;

    always_comb begin
        status_word = '0;
        status_word[0] = not_empty;
        status_word[1] = overflow_reg;
        status_word[2 +: NW] = count_reg;
        data_word = not_empty ? {24'd0, 1'b1, 3'd0, fifo_mem[rd_ptr_reg]} : 32'd0;
        case (reg_sel)
            2'd0:    rd_word = status_word;
            2'd1:    rd_word = data_word;
            2'd2:    rd_word = {30'd0, irq_en_reg, enable_reg};
            default: rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            enable_reg <= 1'b1;
            irq_en_reg <= 1'b0;
            irq        <= 1'b0;
        end else begin
            wb_ack_o <= access;
            irq      <= irq_en_reg & not_empty;
            if (access)
                wb_dat_o <= wb_we_i ? 32'd0 : rd_word;
            if (ctrl_wr) begin
                enable_reg <= wb_dat_i[0];
                irq_en_reg <= wb_dat_i[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row_i;
            row_sync_reg <= row_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            col_o         <= 3'b111;
            col_idx_reg   <= 2'd0;
            dwell_reg     <= '0;
            scan_reg      <= '0;
            scan_done_reg <= 1'b0;
        end else if (!en_eff) begin
            state_reg     <= S_IDLE;
            col_o         <= 3'b111;
            col_idx_reg   <= 2'd0;
            dwell_reg     <= '0;
            scan_done_reg <= 1'b0;
        end else begin
            scan_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    state_reg   <= S_DRIVE;
                    col_idx_reg <= 2'd0;
                    dwell_reg   <= '0;
                    col_o       <= 3'b110;
                end
                default: begin
                    if (dwell_reg == CW'(COL_CYCLES - 1)) begin
                        scan_reg[col_idx_reg*4 +: 4] <= ~row_sync_reg;
                        dwell_reg <= '0;
                        if (col_idx_reg == 2'd2) begin
                            col_idx_reg   <= 2'd0;
                            col_o         <= 3'b110;
                            scan_done_reg <= 1'b1;
                        end else begin
                            col_idx_reg <= col_idx_reg + 2'd1;
                            col_o       <= (col_idx_reg == 2'd0) ? 3'b101 : 3'b011;
                        end
                    end else begin
                        dwell_reg <= dwell_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        v_onehot = (scan_reg != '0) && ((scan_reg & (scan_reg - 12'd1)) == '0);
        key_code = 4'd0;
        for (int i = 0; i < 12; i++)
            if (scan_reg[i]) key_code = 4'(i);
        if (v_onehot && scan_reg == prev_scan_reg)
            press_next = (press_cnt_reg == PW'(DEBOUNCE)) ? press_cnt_reg : press_cnt_reg + 1'b1;
        else
            press_next = v_onehot ? PW'(1) : '0;
        if (scan_reg == '0)
            rel_next = (rel_cnt_reg == PW'(DEBOUNCE)) ? rel_cnt_reg : rel_cnt_reg + 1'b1;
        else
            rel_next = '0;
        push = en_eff & scan_done_reg & armed_reg & (press_next == PW'(DEBOUNCE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_cnt_reg <= '0;
            rel_cnt_reg   <= '0;
            armed_reg     <= 1'b1;
            prev_scan_reg <= '0;
        end else if (!en_eff) begin
            press_cnt_reg <= '0;
            rel_cnt_reg   <= '0;
            armed_reg     <= 1'b1;
            prev_scan_reg <= '0;
        end else if (scan_done_reg) begin
            press_cnt_reg <= press_next;
            rel_cnt_reg   <= rel_next;
            prev_scan_reg <= scan_reg;
            // Held keys stay disarmed until enough all-clear scans are seen.
            if (push)
                armed_reg <= 1'b0;
            else if (rel_next == PW'(DEBOUNCE))
                armed_reg <= 1'b1;
        end
    end

    assign push_ok = push & (~full | rd_pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= key_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !rd_pop)
                count_reg <= count_reg + 1'b1;
            else if (!push_ok && rd_pop)
                count_reg <= count_reg - 1'b1;
            if (push && full && !rd_pop)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_keypad_scanner.sv
// Scoreboard bench for wb_keypad_scanner: a keypad model drives the rows and
// expected key codes are queued as presses are applied, then popped on DATA reads.
module tb_wb_keypad_scanner;
    localparam int COLC  = 8;
    localparam int DEB   = 3;
    localparam int DEPTH = 4;
    localparam int SCAN  = 3 * COLC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic        wb_ack_o;
    logic [3:0]  row_i;
    logic [2:0]  col_o;
    logic        irq;

    logic [11:0] keys = '0;
    logic [7:0]  exp_q[$];
    logic        exp_ovf  = 1'b0;
    logic        tb_armed = 1'b1;
    int          errors = 0;
    int          checks = 0;

    wb_keypad_scanner #(.COL_CYCLES(COLC), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .row_i(row_i), .col_o(col_o), .irq(irq)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_i = 4'hF;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                if (!col_o[c] && keys[c*4 + r]) row_i[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] reg_i, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        int n;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {28'd0, reg_i, 2'b00}; wb_dat_i = wdata;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        check("ack_latency", 32'(n), 32'd1);
        rdata = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        $display("wb %s reg=%0d wdata=%h rdata=%h", we ? "wr" : "rd", reg_i, wdata, rdata);
    endtask

    task automatic wb_write(input logic [1:0] reg_i, input logic [31:0] wdata);
        logic [31:0] d;
        wb_xfer(1'b1, reg_i, wdata, d);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] d, e;
        wb_xfer(1'b0, 2'd0, 32'd0, d);
        e = '0;
        e[0] = (exp_q.size() != 0);
        e[1] = exp_ovf;
        e[4:2] = 3'(exp_q.size());
        check(tag, d, e);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d, e;
        wb_xfer(1'b0, 2'd1, 32'd0, d);
        e = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
        check(tag, d, e);
    endtask

    task automatic read_ctrl(input string tag, input logic [31:0] e);
        logic [31:0] d;
        wb_xfer(1'b0, 2'd2, 32'd0, d);
        check(tag, d, e);
    endtask

    // n scans of wall time contain at least n-1 complete scans.
    task automatic press_key(input logic [11:0] k, input int n);
        int code;
        keys = k;
        code = 0;
        for (int i = 0; i < 12; i++)
            if (k[i]) code = i;
        if ($countones(k) == 1 && n - 1 >= DEB && tb_armed) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'h80 | 8'(code));
            else exp_ovf = 1'b1;
            tb_armed = 1'b0;
        end
        $display("keys=%h held for %0d scans", k, n);
        repeat (n * SCAN) @(posedge clk);
    endtask

    task automatic release_keys(input int n);
        keys = '0;
        if (n - 1 >= DEB) tb_armed = 1'b1;
        $display("keys released for %0d scans", n);
        repeat (n * SCAN) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] col_pat [3];
        int n;
        col_pat[0] = 3'b110; col_pat[1] = 3'b101; col_pat[2] = 3'b011;

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", 32'(col_o), 32'h7);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b1;

        n = 0;
        while (col_o != 3'b110 && n < 4) begin @(negedge clk); n++; end
        for (int i = 0; i < SCAN; i++) begin
            check("col_seq", 32'(col_o), 32'(col_pat[i / COLC]));
            @(negedge clk);
        end
        read_status("status_idle");
        read_data("data_empty");
        read_ctrl("ctrl_reset", 32'h1);

        press_key(12'h040, 10);
        read_status("status_one");
        read_data("data_key6");
        read_data("data_after_pop");
        release_keys(2);
        press_key(12'h040, 6);
        release_keys(5);
        read_status("status_no_repeat");

        press_key(12'h800, 6);
        release_keys(5);
        read_data("data_key11");

        press_key(12'h021, 6);
        release_keys(5);
        read_status("status_multi");

        press_key(12'h001, 5); release_keys(5);
        press_key(12'h002, 5); release_keys(5);
        press_key(12'h010, 5); release_keys(5);
        press_key(12'h200, 5); release_keys(5);
        press_key(12'h400, 5); release_keys(5);
        read_status("status_full_ovf");
        for (int i = 0; i < DEPTH; i++) read_data("data_fifo_order");
        read_data("data_drained");
        read_status("status_ovf_sticky");
        wb_write(2'd0, 32'h2);
        exp_ovf = 1'b0;
        read_status("status_ovf_clr");

        wb_write(2'd2, 32'h3);
        read_ctrl("ctrl_irq_en", 32'h3);
        check("irq_idle", 32'(irq), 32'd0);
        keys = 12'h008;
        if (tb_armed) begin exp_q.push_back(8'h83); tb_armed = 1'b0; end
        n = 0;
        @(negedge clk);
        while (dut.count_reg == '0 && n < 8 * SCAN) begin @(negedge clk); n++; end
        check("push_seen", 32'(dut.count_reg != '0), 32'd1);
        check("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'd1);
        press_key(12'h008, 3);
        release_keys(5);
        read_data("data_key3");
        @(negedge clk); @(negedge clk);
        check("irq_fall", 32'(irq), 32'd0);

        n = 0;
        while (col_o != 3'b101 && n < 2 * SCAN) begin @(negedge clk); n++; end
        check("col1_seen", 32'(col_o), 32'h5);
        repeat (3) @(posedge clk);
        wb_write(2'd2, 32'h2);
        tb_armed = 1'b1;
        check("disable_col", 32'(col_o), 32'h7);
        repeat (30) @(posedge clk);
        #1 check("disabled_hold", 32'(col_o), 32'h7);
        wb_write(2'd2, 32'h1);
        check("reenable_col0", 32'(col_o), 32'h6);

        press_key(12'h080, 5);
        release_keys(5);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h4;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ack", 32'(wb_ack_o), 32'd0);
        check("rst_mid_col", 32'(col_o), 32'h7);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        tb_armed = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        read_status("status_after_rst");
        read_ctrl("ctrl_after_rst", 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
